// File: rtl/stream_unpacker.sv
// Framed AXI4-Stream unpacker: parses a header word (tid/tdest/tuser/length/magic)
// and re-emits the following data words as one AXI4-Stream frame with TKEEP/TLAST.
module stream_unpacker #(
    parameter int         TDATA_BYTES = 8,
    parameter int         TID_WIDTH   = 4,
    parameter int         TDEST_WIDTH = 1,
    parameter int         TUSER_WIDTH = 1,
    parameter int         MAX_BEATS   = 256,
    parameter logic [7:0] MAGIC       = 8'hA5
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     target_tvalid,
    output logic                     target_tready,
    input  logic [8*TDATA_BYTES-1:0] target_tdata,
    output logic                     initiator_tvalid,
    input  logic                     initiator_tready,
    output logic [8*TDATA_BYTES-1:0] initiator_tdata,
    output logic [TDATA_BYTES-1:0]   initiator_tkeep,
    output logic [TID_WIDTH-1:0]     initiator_tid,
    output logic [TDEST_WIDTH-1:0]   initiator_tdest,
    output logic [TUSER_WIDTH-1:0]   initiator_tuser,
    output logic                     initiator_tlast,
    output logic                     hdr_err,
    output logic                     len_err,
    output logic [31:0]              frame_cnt,
    output logic [15:0]              err_cnt
);
    localparam int          DW          = 8 * TDATA_BYTES;
    localparam logic [16:0] MAX_BEATS_W = 17'(MAX_BEATS);

    typedef enum logic [1:0] {HDR, DATA, DROP} state_t;

    state_t                   state_reg, state_next;
    logic [15:0]              remaining_reg, remaining_next;
    logic [7:0]               last_bytes_reg, last_bytes_next;
    logic [TID_WIDTH-1:0]     hdr_tid_reg, hdr_tid_next;
    logic [TDEST_WIDTH-1:0]   hdr_tdest_reg, hdr_tdest_next;
    logic [TUSER_WIDTH-1:0]   hdr_tuser_reg, hdr_tuser_next;

    logic                     tvalid_reg, tvalid_next;
    logic [DW-1:0]            tdata_reg, tdata_next;
    logic [TDATA_BYTES-1:0]   tkeep_reg, tkeep_next;
    logic [TID_WIDTH-1:0]     tid_reg, tid_next;
    logic [TDEST_WIDTH-1:0]   tdest_reg, tdest_next;
    logic [TUSER_WIDTH-1:0]   tuser_reg, tuser_next;
    logic                     tlast_reg, tlast_next;

    logic                     hdr_err_reg, hdr_err_next;
    logic                     len_err_reg, len_err_next;
    logic [31:0]              frame_cnt_reg, frame_cnt_next;
    logic [15:0]              err_cnt_reg, err_cnt_next;

    logic                     accept;
    logic [15:0]              word_beat_cnt;
    logic [TDATA_BYTES-1:0]   last_keep;

    assign word_beat_cnt = target_tdata[31:16];
    assign target_tready = (state_reg != DATA) || !tvalid_reg || initiator_tready;
    assign accept        = target_tvalid && target_tready;

    // Byte gi is kept on the last beat when gi <= last_bytes; large values saturate to all ones.
    genvar gi;
    generate
        for (gi = 0; gi < TDATA_BYTES; gi++) begin : g_last_keep
            assign last_keep[gi] = (32'(last_bytes_reg) >= 32'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        last_bytes_next = last_bytes_reg;
        hdr_tid_next    = hdr_tid_reg;
        hdr_tdest_next  = hdr_tdest_reg;
        hdr_tuser_next  = hdr_tuser_reg;
        tvalid_next     = tvalid_reg && !initiator_tready;
        tdata_next      = tdata_reg;
        tkeep_next      = tkeep_reg;
        tid_next        = tid_reg;
        tdest_next      = tdest_reg;
        tuser_next      = tuser_reg;
        tlast_next      = tlast_reg;
        hdr_err_next    = 1'b0;
        len_err_next    = 1'b0;
        frame_cnt_next  = frame_cnt_reg;
        err_cnt_next    = err_cnt_reg;

        case (state_reg)
            HDR: begin
                if (accept) begin
                    if (target_tdata[63:56] != MAGIC) begin
                        hdr_err_next = 1'b1;
                    end else if (({1'b0, word_beat_cnt} + 17'd1) > MAX_BEATS_W) begin
                        len_err_next   = 1'b1;
                        remaining_next = word_beat_cnt;
                        state_next     = DROP;
                    end else begin
                        hdr_tid_next    = target_tdata[TID_WIDTH-1:0];
                        hdr_tdest_next  = target_tdata[8 +: TDEST_WIDTH];
                        hdr_tuser_next  = target_tdata[40 +: TUSER_WIDTH];
                        last_bytes_next = target_tdata[39:32];
                        remaining_next  = word_beat_cnt;
                        state_next      = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    tvalid_next    = 1'b1;
                    tdata_next     = target_tdata;
                    tid_next       = hdr_tid_reg;
                    tdest_next     = hdr_tdest_reg;
                    tuser_next     = hdr_tuser_reg;
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd0) begin
                        tlast_next     = 1'b1;
                        tkeep_next     = last_keep;
                        state_next     = HDR;
                        frame_cnt_next = frame_cnt_reg + 32'd1;
                    end else begin
                        tlast_next = 1'b0;
                        tkeep_next = '1;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    remaining_next = remaining_reg - 16'd1;
                    if (remaining_reg == 16'd0) begin
                        state_next = HDR;
                    end
                end
            end
            default: state_next = HDR;
        endcase

        if ((hdr_err_next || len_err_next) && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_next = err_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= HDR;
            remaining_reg  <= '0;
            last_bytes_reg <= '0;
            hdr_tid_reg    <= '0;
            hdr_tdest_reg  <= '0;
            hdr_tuser_reg  <= '0;
            tvalid_reg     <= 1'b0;
            tdata_reg      <= '0;
            tkeep_reg      <= '0;
            tid_reg        <= '0;
            tdest_reg      <= '0;
            tuser_reg      <= '0;
            tlast_reg      <= 1'b0;
            hdr_err_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
            frame_cnt_reg  <= '0;
            err_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            last_bytes_reg <= last_bytes_next;
            hdr_tid_reg    <= hdr_tid_next;
            hdr_tdest_reg  <= hdr_tdest_next;
            hdr_tuser_reg  <= hdr_tuser_next;
            tvalid_reg     <= tvalid_next;
            tdata_reg      <= tdata_next;
            tkeep_reg      <= tkeep_next;
            tid_reg        <= tid_next;
            tdest_reg      <= tdest_next;
            tuser_reg      <= tuser_next;
            tlast_reg      <= tlast_next;
            hdr_err_reg    <= hdr_err_next;
            len_err_reg    <= len_err_next;
            frame_cnt_reg  <= frame_cnt_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    assign initiator_tvalid = tvalid_reg;
    assign initiator_tdata  = tdata_reg;
    assign initiator_tkeep  = tkeep_reg;
    assign initiator_tid    = tid_reg;
    assign initiator_tdest  = tdest_reg;
    assign initiator_tuser  = tuser_reg;
    assign initiator_tlast  = tlast_reg;
    assign hdr_err          = hdr_err_reg;
    assign len_err          = len_err_reg;
    assign frame_cnt        = frame_cnt_reg;
    assign err_cnt          = err_cnt_reg;

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: sends header/data words and compares emitted
// beats, error pulses and counters against hand-computed expectations.
module tb_stream_unpacker;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        target_tvalid;
    logic        target_tready;
    logic [63:0] target_tdata;
    logic        initiator_tvalid;
    logic        initiator_tready;
    logic [63:0] initiator_tdata;
    logic [7:0]  initiator_tkeep;
    logic [3:0]  initiator_tid;
    logic        initiator_tdest;
    logic        initiator_tuser;
    logic        initiator_tlast;
    logic        hdr_err;
    logic        len_err;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [3:0]  tid;
        logic        tdest;
        logic        tuser;
        logic        last;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t cur_beat;
    beat_t prev_beat;
    logic  prev_stall = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    hdr_pulses = 0;
    int    len_pulses = 0;
    logic  stall_mode = 1'b0;
    logic  gap_mode = 1'b0;

    stream_unpacker dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .target_tvalid    (target_tvalid),
        .target_tready    (target_tready),
        .target_tdata     (target_tdata),
        .initiator_tvalid (initiator_tvalid),
        .initiator_tready (initiator_tready),
        .initiator_tdata  (initiator_tdata),
        .initiator_tkeep  (initiator_tkeep),
        .initiator_tid    (initiator_tid),
        .initiator_tdest  (initiator_tdest),
        .initiator_tuser  (initiator_tuser),
        .initiator_tlast  (initiator_tlast),
        .hdr_err          (hdr_err),
        .len_err          (len_err),
        .frame_cnt        (frame_cnt),
        .err_cnt          (err_cnt)
    );

    always #5 aclk = ~aclk;

    assign cur_beat = {initiator_tdata, initiator_tkeep, initiator_tid,
                       initiator_tdest, initiator_tuser, initiator_tlast};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [7:0] tdest,
                                        input logic [15:0] bc, input logic [7:0] lb,
                                        input logic [7:0] tuser, input logic [7:0] magic);
        // Byte 6 filled with junk: it must be ignored.
        return {magic, 8'h66, tuser, lb, bc, tdest, tid};
    endfunction

    // Downstream ready: always 1, or the repeating pattern 1,0,0,1,0,1.
    initial begin
        logic [5:0] pat;
        int         idx;
        pat = 6'b101001;
        idx = 0;
        initiator_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (stall_mode) begin
                initiator_tready = pat[idx];
                idx = (idx + 1) % 6;
            end else begin
                initiator_tready = 1'b1;
                idx = 0;
            end
        end
    end

    // Output monitor: collects accepted beats, checks stall stability and backpressure.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall) begin
                check_val("stall_tvalid", 64'(initiator_tvalid), 64'd1);
                check_val("stall_data", initiator_tdata, prev_beat.data);
                check_val("stall_meta", 64'(cur_beat[14:0]), 64'(prev_beat[14:0]));
            end
            if (initiator_tvalid && !initiator_tready && !initiator_tlast)
                check_val("backpressure", 64'(target_tready), 64'd0);
            if (initiator_tvalid && initiator_tready) begin
                got_q.push_back(cur_beat);
                $display("beat data=%h keep=%h tid=%0d tdest=%0d tuser=%0d last=%0d",
                         initiator_tdata, initiator_tkeep, initiator_tid,
                         initiator_tdest, initiator_tuser, initiator_tlast);
            end
            if (hdr_err) hdr_pulses++;
            if (len_err) len_pulses++;
            prev_stall = initiator_tvalid && !initiator_tready;
            prev_beat  = cur_beat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [63:0] w);
        int n;
        if (gap_mode) begin
            target_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge aclk);
                #1;
            end
        end
        target_tvalid = 1'b1;
        target_tdata  = w;
        n = 0;
        forever begin
            @(negedge aclk);
            if (target_tready) break;
            n++;
            if (n > 100) begin
                check_val("send_timeout", 64'(target_tready), 64'd1);
                break;
            end
        end
        @(posedge aclk);
        #1;
        target_tvalid = 1'b0;
    endtask

    task automatic send_data(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) send(base + 64'(i));
    endtask

    task automatic exp_beat(input logic [63:0] d, input logic [7:0] k, input logic [3:0] tid,
                            input logic tdest, input logic tuser, input logic last);
        beat_t b;
        b = {d, k, tid, tdest, tuser, last};
        exp_q.push_back(b);
    endtask

    task automatic wait_beats(input int n);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 300) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        if (got_q.size() < n) check_val("beat_timeout", 64'(got_q.size()), 64'(n));
        repeat (6) @(posedge aclk);
        #1;
    endtask

    task automatic compare_beats(input string tag);
        check_val({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val({tag, "_data"}, got_q[i].data, exp_q[i].data);
            check_val({tag, "_keep"}, 64'(got_q[i].keep), 64'(exp_q[i].keep));
            check_val({tag, "_ids"}, 64'({got_q[i].tid, got_q[i].tdest, got_q[i].tuser}),
                      64'({exp_q[i].tid, exp_q[i].tdest, exp_q[i].tuser}));
            check_val({tag, "_last"}, 64'(got_q[i].last), 64'(exp_q[i].last));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        target_tvalid = 1'b0;
        stall_mode    = 1'b0;
        gap_mode      = 1'b0;
        aresetn       = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        got_q.delete();
        exp_q.delete();
        hdr_pulses = 0;
        len_pulses = 0;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn       = 1'b0;
        target_tvalid = 1'b0;
        target_tdata  = '0;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_val("rst_tvalid", 64'(initiator_tvalid), 64'd0);
        check_val("rst_tdata", initiator_tdata, 64'd0);
        check_val("rst_tkeep", 64'(initiator_tkeep), 64'd0);
        check_val("rst_tlast", 64'(initiator_tlast), 64'd0);
        check_val("rst_counts", 64'({frame_cnt, err_cnt}), 64'd0);
        check_val("rst_errs", 64'({hdr_err, len_err}), 64'd0);
        do_reset();
        check_val("idle_tready", 64'(target_tready), 64'd1);

        // Basic 3-beat frame
        send(hdr(8'hF3, 8'h01, 16'd2, 8'd4, 8'h01, 8'hA5));
        send_data(64'h1111_2222_3333_0000, 3);
        exp_beat(64'h1111_2222_3333_0000, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
        exp_beat(64'h1111_2222_3333_0001, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
        exp_beat(64'h1111_2222_3333_0002, 8'h1F, 4'd3, 1'b1, 1'b1, 1'b1);
        wait_beats(3);
        compare_beats("basic");
        check_val("basic_frame_cnt", 64'(frame_cnt), 64'd1);
        check_val("basic_err_cnt", 64'(err_cnt), 64'd0);

        // Same frame under downstream stalls and random source gaps
        do_reset();
        stall_mode = 1'b1;
        gap_mode   = 1'b1;
        send(hdr(8'h03, 8'h01, 16'd2, 8'd4, 8'h01, 8'hA5));
        send_data(64'hAAAA_0000_0000_0010, 3);
        exp_beat(64'hAAAA_0000_0000_0010, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
        exp_beat(64'hAAAA_0000_0000_0011, 8'hFF, 4'd3, 1'b1, 1'b1, 1'b0);
        exp_beat(64'hAAAA_0000_0000_0012, 8'h1F, 4'd3, 1'b1, 1'b1, 1'b1);
        wait_beats(3);
        compare_beats("stall");
        check_val("stall_frame_cnt", 64'(frame_cnt), 64'd1);

        // Bad magic, then a valid single-beat frame
        do_reset();
        send(hdr(8'h02, 8'h00, 16'd0, 8'd7, 8'h00, 8'h00));
        send(hdr(8'h07, 8'h00, 16'd0, 8'd7, 8'h00, 8'hA5));
        send(64'hBEEF_0000_0000_0001);
        exp_beat(64'hBEEF_0000_0000_0001, 8'hFF, 4'd7, 1'b0, 1'b0, 1'b1);
        wait_beats(1);
        compare_beats("magic");
        check_val("magic_hdr_pulse", 64'(hdr_pulses), 64'd1);
        check_val("magic_len_pulse", 64'(len_pulses), 64'd0);
        check_val("magic_err_cnt", 64'(err_cnt), 64'd1);
        check_val("magic_frame_cnt", 64'(frame_cnt), 64'd1);

        // Oversized frame (257 beats) dropped, then a 2-beat frame
        do_reset();
        send(hdr(8'h01, 8'h01, 16'd256, 8'd7, 8'h00, 8'hA5));
        send_data(64'hDEAD_0000_0000_0000, 257);
        send(hdr(8'h09, 8'h00, 16'd1, 8'd7, 8'h01, 8'hA5));
        send_data(64'hC0DE_0000_0000_0000, 2);
        exp_beat(64'hC0DE_0000_0000_0000, 8'hFF, 4'd9, 1'b0, 1'b1, 1'b0);
        exp_beat(64'hC0DE_0000_0000_0001, 8'hFF, 4'd9, 1'b0, 1'b1, 1'b1);
        wait_beats(2);
        compare_beats("len");
        check_val("len_pulse", 64'(len_pulses), 64'd1);
        check_val("len_hdr_pulse", 64'(hdr_pulses), 64'd0);
        check_val("len_err_cnt", 64'(err_cnt), 64'd1);
        check_val("len_frame_cnt", 64'(frame_cnt), 64'd1);

        // Single-beat frames with last_bytes 7, 0, 9 (clamped)
        do_reset();
        send(hdr(8'h04, 8'h00, 16'd0, 8'd7, 8'h00, 8'hA5));
        send(64'h5555_0000_0000_0000);
        send(hdr(8'h05, 8'h01, 16'd0, 8'd0, 8'h00, 8'hA5));
        send(64'h5555_0000_0000_0001);
        send(hdr(8'h06, 8'h00, 16'd0, 8'd9, 8'h01, 8'hA5));
        send(64'h5555_0000_0000_0002);
        exp_beat(64'h5555_0000_0000_0000, 8'hFF, 4'd4, 1'b0, 1'b0, 1'b1);
        exp_beat(64'h5555_0000_0000_0001, 8'h01, 4'd5, 1'b1, 1'b0, 1'b1);
        exp_beat(64'h5555_0000_0000_0002, 8'hFF, 4'd6, 1'b0, 1'b1, 1'b1);
        wait_beats(3);
        compare_beats("single");
        check_val("single_frame_cnt", 64'(frame_cnt), 64'd3);

        // Reset after 2 of 5 beats; frame_cnt is 3 from the previous test
        send(hdr(8'h08, 8'h01, 16'd4, 8'd7, 8'h01, 8'hA5));
        send_data(64'h7777_0000_0000_0000, 2);
        wait_beats(2);
        got_q.delete();
        aresetn = 1'b0;
        @(negedge aclk);
        check_val("midrst_tvalid", 64'(initiator_tvalid), 64'd0);
        check_val("midrst_tdata", initiator_tdata, 64'd0);
        check_val("midrst_meta", 64'(cur_beat[14:0]), 64'd0);
        check_val("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        send(hdr(8'h0A, 8'h00, 16'd1, 8'd2, 8'h00, 8'hA5));
        send_data(64'h9999_0000_0000_0000, 2);
        exp_beat(64'h9999_0000_0000_0000, 8'hFF, 4'd10, 1'b0, 1'b0, 1'b0);
        exp_beat(64'h9999_0000_0000_0001, 8'h07, 4'd10, 1'b0, 1'b0, 1'b1);
        wait_beats(2);
        compare_beats("midrst");
        check_val("midrst_frame_cnt_after", 64'(frame_cnt), 64'd1);
        check_val("midrst_err_cnt", 64'(err_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
